// File: rtl/decoder_scan_n.sv
// N-to-2^N one-hot decoder with registered outputs, enable, and a self-stepping scan mode.
// SCAN holds each line for DIV cycles, starting from the address sampled on entry.
module decoder_scan_n #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 E,
    input  logic                 mode,
    input  logic [N-1:0]         A,
    output logic [(1<<N)-1:0]    Y,
    output logic [N-1:0]         idx,
    output logic                 wrap
);

    localparam int W  = 1 << N;
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [N-1:0]  IDX_LAST  = N'(W - 1);

    typedef enum logic [0:0] {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [W-1:0]    y_r, y_s;
    logic [N-1:0]    idx_r, idx_s;
    logic [N-1:0]    idx_inc_s;
    logic [TW-1:0]   tick_r, tick_s;
    logic            wrap_r, wrap_s;

    function automatic logic [W-1:0] one_hot(input logic [N-1:0] sel);
        logic [W-1:0] r;
        r      = {W{1'b0}};
        r[sel] = 1'b1;
        return r;
    endfunction

    assign idx_inc_s = idx_r + N'(1);

    // Next-state and next-output logic for the DIRECT/SCAN controller.
    always_comb begin
        state_s = state_r;
        y_s     = y_r;
        idx_s   = idx_r;
        tick_s  = tick_r;
        wrap_s  = 1'b0;
        case (state_r)
            S_DIRECT: begin
                if (mode) begin
                    state_s = S_SCAN;
                    tick_s  = {TW{1'b0}};
                end else begin
                    state_s = S_DIRECT;
                    tick_s  = tick_r;
                end
                idx_s = A;
                y_s   = E ? one_hot(A) : {W{1'b0}};
            end
            S_SCAN: begin
                if (!mode) begin
                    state_s = S_DIRECT;
                    tick_s  = {TW{1'b0}};
                    idx_s   = A;
                    y_s     = E ? one_hot(A) : {W{1'b0}};
                end else if (!E) begin
                    // Paused: index and tick are frozen so the dwell resumes where it stopped.
                    y_s = {W{1'b0}};
                end else if (tick_r == TICK_LAST) begin
                    tick_s = {TW{1'b0}};
                    idx_s  = idx_inc_s;
                    y_s    = one_hot(idx_inc_s);
                    wrap_s = (idx_r == IDX_LAST);
                end else begin
                    tick_s = tick_r + TW'(1);
                    y_s    = one_hot(idx_r);
                end
            end
            default: begin
                state_s = S_DIRECT;
                tick_s  = {TW{1'b0}};
                idx_s   = {N{1'b0}};
                y_s     = {W{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_DIRECT;
            y_r     <= {W{1'b0}};
            idx_r   <= {N{1'b0}};
            tick_r  <= {TW{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            y_r     <= y_s;
            idx_r   <= idx_s;
            tick_r  <= tick_s;
            wrap_r  <= wrap_s;
        end
    end

    assign Y    = y_r;
    assign idx  = idx_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed scoreboard bench for decoder_scan_n: N=3/DIV=4 instance plus an N=2/DIV=1 instance.
module tb_decoder_scan_n;

    logic       clk;
    logic       rst_n;
    logic       e1, mode1;
    logic [2:0] a1;
    logic [7:0] y1;
    logic [2:0] idx1;
    logic       wrap1;
    logic       e2, mode2;
    logic [1:0] a2;
    logic [3:0] y2;
    logic [1:0] idx2;
    logic       wrap2;

    int n_pass;
    int n_fail;
    int n_total;

    typedef struct {
        string      tag;
        logic       sel;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    exp_t sb_q[$];

    decoder_scan_n #(.N(3), .DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .E(e1), .mode(mode1), .A(a1),
        .Y(y1), .idx(idx1), .wrap(wrap1)
    );

    decoder_scan_n #(.N(2), .DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .E(e2), .mode(mode2), .A(a2),
        .Y(y2), .idx(idx2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic sel, input logic [7:0] y,
                        input logic [2:0] i, input logic w);
        exp_t x;
        x.tag = tag; x.sel = sel; x.y = y; x.idx = i; x.wrap = w;
        sb_q.push_back(x);
    endtask

    task automatic check_now();
        exp_t x;
        x = sb_q.pop_front();
        if (x.sel) begin
            cmp({x.tag, ".Y"},    {4'h0, y2},    x.y);
            cmp({x.tag, ".idx"},  {1'b0, idx2},  x.idx);
            cmp({x.tag, ".wrap"}, {7'h00, wrap2}, {7'h00, x.wrap});
        end else begin
            cmp({x.tag, ".Y"},    y1,             x.y);
            cmp({x.tag, ".idx"},  {5'h00, idx1}, {5'h00, x.idx});
            cmp({x.tag, ".wrap"}, {7'h00, wrap1}, {7'h00, x.wrap});
        end
    endtask

    // One clock of the N=3 instance: drive, record expectation, sample after the edge.
    task automatic cyc(input string tag, input logic e, input logic m, input logic [2:0] a,
                       input logic [7:0] ey, input logic [2:0] ei, input logic ew);
        e1 = e; mode1 = m; a1 = a;
        push(tag, 1'b0, ey, ei, ew);
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic cyc2(input string tag, input logic e, input logic m, input logic [1:0] a,
                        input logic [3:0] ey, input logic [1:0] ei, input logic ew);
        e2 = e; mode2 = m; a2 = a;
        push(tag, 1'b1, {4'h0, ey}, {1'b0, ei}, ew);
        @(posedge clk);
        #1;
        check_now();
    endtask

    // Y must be one-hot or zero on both instances at every cycle.
    always @(negedge clk) begin
        cmp("onehot1", {7'h00, $onehot0(y1)}, 8'h01);
        cmp("onehot2", {7'h00, $onehot0(y2)}, 8'h01);
    end

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        rst_n = 1'b0;
        e1 = 1'b0; mode1 = 1'b0; a1 = 3'd0;
        e2 = 1'b0; mode2 = 1'b0; a2 = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle
        cyc("pre_rst", 1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b0);
        e1 = 1'b1; mode1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst", 1'b0, 8'h00, 3'd0, 1'b0);
        check_now();
        @(negedge clk);
        mode1 = 1'b0;
        rst_n = 1'b1;

        // DIRECT sweep
        cyc("dir_off", 1'b0, 1'b0, 3'd3, 8'h00, 3'd3, 1'b0);
        for (int a = 0; a < 8; a++)
            cyc("dir_sweep", 1'b1, 1'b0, 3'(a), 8'h01 << a, 3'(a), 1'b0);

        // SCAN entry from 6, through wrap
        cyc("scan_entry", 1'b1, 1'b1, 3'd6, 8'h40, 3'd6, 1'b0);
        for (int k = 0; k < 3; k++) cyc("scan_6", 1'b1, 1'b1, 3'd0, 8'h40, 3'd6, 1'b0);
        for (int k = 0; k < 4; k++) cyc("scan_7", 1'b1, 1'b1, 3'd2, 8'h80, 3'd7, 1'b0);
        cyc("scan_wrap", 1'b1, 1'b1, 3'd5, 8'h01, 3'd0, 1'b1);
        for (int k = 0; k < 3; k++) cyc("scan_0", 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) cyc("scan_1", 1'b1, 1'b1, 3'd0, 8'h02, 3'd1, 1'b0);
        for (int k = 0; k < 2; k++) cyc("scan_2", 1'b1, 1'b1, 3'd0, 8'h04, 3'd2, 1'b0);

        // Pause at idx=2, tick=1
        for (int k = 0; k < 5; k++) cyc("pause", 1'b0, 1'b1, 3'd7, 8'h00, 3'd2, 1'b0);
        for (int k = 0; k < 2; k++) cyc("resume_2", 1'b1, 1'b1, 3'd7, 8'h04, 3'd2, 1'b0);
        for (int k = 0; k < 4; k++) cyc("scan_3", 1'b1, 1'b1, 3'd0, 8'h08, 3'd3, 1'b0);
        for (int k = 0; k < 4; k++) cyc("scan_4", 1'b1, 1'b1, 3'd0, 8'h10, 3'd4, 1'b0);
        cyc("scan_5", 1'b1, 1'b1, 3'd0, 8'h20, 3'd5, 1'b0);

        // Mode switch mid-scan, then re-entry at 7
        cyc("to_direct", 1'b1, 1'b0, 3'd1, 8'h02, 3'd1, 1'b0);
        cyc("reentry", 1'b1, 1'b1, 3'd7, 8'h80, 3'd7, 1'b0);
        for (int k = 0; k < 3; k++) cyc("reentry_7", 1'b1, 1'b1, 3'd3, 8'h80, 3'd7, 1'b0);
        cyc("reentry_wrap", 1'b1, 1'b1, 3'd3, 8'h01, 3'd0, 1'b1);
        cyc("wrap_once", 1'b1, 1'b1, 3'd3, 8'h01, 3'd0, 1'b0);

        // Mode change with E=0 in both directions
        cyc("to_direct_off", 1'b0, 1'b0, 3'd4, 8'h00, 3'd4, 1'b0);
        cyc("to_scan_off", 1'b0, 1'b1, 3'd2, 8'h00, 3'd2, 1'b0);
        cyc("scan_on", 1'b1, 1'b1, 3'd6, 8'h04, 3'd2, 1'b0);
        cyc("back_direct", 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0);

        // DIV=1, N=2 instance: advance every cycle, wrap every 4th
        cyc2("d1_entry", 1'b1, 1'b1, 2'd0, 4'h1, 2'd0, 1'b0);
        for (int k = 1; k <= 8; k++)
            cyc2("d1_scan", 1'b1, 1'b1, 2'd0, 4'h1 << (k % 4), 2'(k % 4), (k % 4) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
